// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage and its load-response queue.
package wb_pkg;

    localparam int REG_W   = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    // funct3 is kept as raw bits so that unlisted encodings survive until extension
    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [REG_W-1:0]   data;
        logic [2:0]         funct3;
        logic [1:0]         byte_off;
    } lq_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// Small FIFO of load responses waiting for a register-file write slot.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  lq_entry_t                      push_entry,
    input  logic                           pop,
    output lq_entry_t                      head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    lq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates ALU results and queued load responses onto the register-file write port.
// Optional macro WB_FORWARD_EN adds a write-to-read bypass for the two decode read ports.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [REG_W-1:0]   alu_result,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [RADDR_W-1:0] lsu_rd,
    input  logic [REG_W-1:0]   lsu_data,
    input  logic [2:0]         lsu_funct3,
    input  logic [1:0]         lsu_byte_off,
    input  logic               ld_issue_valid,
    input  logic [RADDR_W-1:0] ld_issue_rd,
    output logic [REG_W-1:0]   rd_pending,
`ifdef WB_FORWARD_EN
    input  logic [RADDR_W-1:0] read_a_ptr,
    input  logic [RADDR_W-1:0] read_b_ptr,
    input  logic [REG_W-1:0]   rf_a,
    input  logic [REG_W-1:0]   rf_b,
    output logic [REG_W-1:0]   fwd_a,
    output logic [REG_W-1:0]   fwd_b,
`endif
    output logic               write_en,
    output logic [RADDR_W-1:0] write_ptr,
    output logic [REG_W-1:0]   write_data
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam logic [CW-1:0] LQ_HI_WATER = CW'(LQ_DEPTH - 1);

    function automatic logic [REG_W-1:0] extend_load(
        input logic [REG_W-1:0] word,
        input logic [2:0]       funct3,
        input logic [1:0]       byte_off
    );
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane_b = word[{byte_off, 3'b000} +: 8];
        lane_h = byte_off[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      return 32'(lane_b);
            LH:      return 32'(lane_h);
            LBU:     return {24'b0, lane_b};
            LHU:     return {16'b0, lane_h};
            default: return word;
        endcase
    endfunction

    lq_entry_t           lq_in;
    lq_entry_t           lq_head;
    logic                lq_full;
    logic                lq_empty;
    logic [CW-1:0]       lq_count;
    logic                lq_push;
    logic                lq_pop;
    logic                alu_take;
    logic                win_vld;
    logic [RADDR_W-1:0]  win_rd;
    logic [REG_W-1:0]    win_val;
    logic [REG_W-1:0]    pend_set;
    logic [REG_W-1:0]    pend_clr;

    assign lq_in = '{rd: lsu_rd, data: lsu_data, funct3: lsu_funct3, byte_off: lsu_byte_off};

    wb_load_queue #(
        .DEPTH      (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (lq_push),
        .push_entry (lq_in),
        .pop        (lq_pop),
        .head       (lq_head),
        .full       (lq_full),
        .empty      (lq_empty),
        .count      (lq_count)
    );

    // Loads take the port when the ALU is idle or the queue is close to overflowing.
    assign lq_pop    = !lq_empty && ((lq_count >= LQ_HI_WATER) || !alu_valid);
    assign alu_ready = !lq_pop;
    assign alu_take  = alu_valid && alu_ready;
    assign lsu_ready = !lq_full;
    assign lq_push   = lsu_valid && lsu_ready;

    always_comb begin
        win_vld = 1'b0;
        win_rd  = '0;
        win_val = '0;
        if (lq_pop) begin
            win_vld = 1'b1;
            win_rd  = lq_head.rd;
            win_val = extend_load(lq_head.data, lq_head.funct3, lq_head.byte_off);
        end else if (alu_take) begin
            win_vld = 1'b1;
            win_rd  = alu_rd;
            win_val = alu_result;
        end
    end

    // Write port stage: an x0 destination is consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            write_ptr  <= '0;
            write_data <= '0;
        end else begin
            write_en <= win_vld && (win_rd != '0);
            if (win_vld && (win_rd != '0)) begin
                write_ptr  <= win_rd;
                write_data <= win_val;
            end
        end
    end

    // A new issue to the same rd outranks the retiring load, so set is applied after clear.
    assign pend_set = ld_issue_valid ? (REG_W'(1) << ld_issue_rd) : '0;
    assign pend_clr = lq_pop ? (REG_W'(1) << lq_head.rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= '0;
        end else begin
            rd_pending <= ((rd_pending & ~pend_clr) | pend_set) & ~REG_W'(1);
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_a = (write_en && (write_ptr == read_a_ptr) && (read_a_ptr != '0)) ? write_data : rf_a;
    assign fwd_b = (write_en && (write_ptr == read_b_ptr) && (read_b_ptr != '0)) ? write_data : rf_b;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a reference model predicts arbitration, extension and pending bits.
module tb_writeback_unit;

    localparam int LQ_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [2:0]  lsu_funct3;
    logic [1:0]  lsu_byte_off;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [31:0] rd_pending;
    logic        write_en;
    logic [4:0]  write_ptr;
    logic [31:0] write_data;
`ifdef WB_FORWARD_EN
    logic [4:0]  read_a_ptr;
    logic [4:0]  read_b_ptr;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
`endif

    writeback_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_result     (alu_result),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .lsu_funct3     (lsu_funct3),
        .lsu_byte_off   (lsu_byte_off),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_rd    (ld_issue_rd),
        .rd_pending     (rd_pending),
`ifdef WB_FORWARD_EN
        .read_a_ptr     (read_a_ptr),
        .read_b_ptr     (read_b_ptr),
        .rf_a           (rf_a),
        .rf_b           (rf_b),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
`endif
        .write_en       (write_en),
        .write_ptr      (write_ptr),
        .write_data     (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [1:0]  off;
    } ld_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    ld_t         mq[$];
    wr_t         exp_q[$];
    logic [31:0] pend_m;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [2:0] f, input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (off * 8)) & 32'h0000_00FF;
        h = off[1] ? (d >> 16) : (d & 32'h0000_FFFF);
        case (f)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                          input logic [2:0] lf3, input logic [1:0] loff,
                          input logic iv, input logic [4:0] ird);
        alu_valid      = av;
        alu_rd         = ard;
        alu_result     = ares;
        lsu_valid      = lv;
        lsu_rd         = lrd;
        lsu_data       = ldat;
        lsu_funct3     = lf3;
        lsu_byte_off   = loff;
        ld_issue_valid = iv;
        ld_issue_rd    = ird;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
    endtask

    // One clock of stimulus: predict from the model, advance the clock, then compare.
    task automatic cycle();
        ld_t         e;
        wr_t         w;
        bit          head_win;
        bit          ready_m;
        logic [31:0] set_m;
        logic [31:0] clr_m;
        #1;
        ready_m  = (mq.size() < LQ_DEPTH);
        head_win = (mq.size() != 0) && ((mq.size() >= LQ_DEPTH - 1) || !alu_valid);
        check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, !head_win});
        check_eq("lsu_ready", {31'd0, lsu_ready}, {31'd0, ready_m});
        clr_m = 32'd0;
        if (head_win) begin
            e = mq.pop_front();
            clr_m = 32'd1 << e.rd;
            if (e.rd != 5'd0) exp_q.push_back('{rd: e.rd, val: model_ext(e.data, e.f3, e.off)});
        end else if (alu_valid && alu_rd != 5'd0) begin
            exp_q.push_back('{rd: alu_rd, val: alu_result});
        end
        if (lsu_valid && ready_m)
            mq.push_back('{rd: lsu_rd, data: lsu_data, f3: lsu_funct3, off: lsu_byte_off});
        set_m  = ld_issue_valid ? (32'd1 << ld_issue_rd) : 32'd0;
        pend_m = ((pend_m & ~clr_m) | set_m) & 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check_eq("write_en", {31'd0, write_en}, 32'd1);
            check_eq("write_ptr", {27'd0, write_ptr}, {27'd0, w.rd});
            check_eq("write_data", write_data, w.val);
        end else begin
            check_eq("write_en_idle", {31'd0, write_en}, 32'd0);
        end
        check_eq("rd_pending", rd_pending, pend_m);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pend_m   = 32'd0;
        rst_n    = 1'b0;
        idle();
`ifdef WB_FORWARD_EN
        read_a_ptr = 5'd0;
        read_b_ptr = 5'd0;
        rf_a       = 32'd0;
        rf_b       = 32'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_write_en", {31'd0, write_en}, 32'd0);
        check_eq("rst_write_ptr", {27'd0, write_ptr}, 32'd0);
        check_eq("rst_write_data", write_data, 32'd0);
        check_eq("rst_rd_pending", rd_pending, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);

        // ALU-only traffic, including an x0 destination
        set_in(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0); cycle();
        set_in(1'b1, 5'd0, 32'hCAFE_0000, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0); cycle();
        set_in(1'b1, 5'd31, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0); cycle();
        idle(); cycle();

        // Extension of each load type
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h80FF_7F81, 3'b000, 2'd0, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h80FF_7F81, 3'b100, 2'd3, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h80FF_7F81, 3'b001, 2'd2, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h80FF_7F81, 3'b101, 2'd0, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h80FF_7F81, 3'b010, 2'd1, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h80FF_7F81, 3'b111, 2'd3, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h80FF_7F81, 3'b000, 2'd1, 1'b0, 5'd0); cycle();
        idle(); cycle();
        idle(); cycle();

        // Arbitration: ALU held valid while loads accumulate
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'(10 + i), 32'hA000_0000 + i, 1'b1, 5'(20 + i), 32'h0000_1000 * (i + 1),
                   3'b010, 2'd0, 1'b0, 5'd0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(14 + i), 32'hB000_0000 + i, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            idle(); cycle();
        end

        // Pending-load scoreboard
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd7); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0077, 3'b010, 2'd0, 1'b0, 5'd0); cycle();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd7); cycle();
        check_eq("pend7_kept", {31'd0, rd_pending[7]}, 32'd1);
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0078, 3'b010, 2'd0, 1'b0, 5'd0); cycle();
        idle(); cycle();
        check_eq("pend7_cleared", {31'd0, rd_pending[7]}, 32'd0);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, 5'd0); cycle();
        check_eq("pend_x0", rd_pending, 32'd0);

`ifdef WB_FORWARD_EN
        set_in(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0); cycle();
        read_a_ptr = 5'd9;
        rf_a       = 32'd0;
        read_b_ptr = 5'd0;
        rf_b       = 32'h5555_AAAA;
        #1;
        check_eq("fwd_a_hit", fwd_a, 32'hDEAD_BEEF);
        check_eq("fwd_b_x0", fwd_b, 32'h5555_AAAA);
        idle(); cycle();
        check_eq("fwd_a_idle", fwd_a, 32'd0);
`endif

        // Reset mid-stream with three loads queued and writes in flight
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(11 + i), 32'hC000_0000 + i, 1'b1, 5'(24 + i), 32'h0000_00F0 + i,
                   3'b010, 2'd0, 1'b1, 5'(24 + i));
            cycle();
        end
        check_eq("pre_rst_queued", mq.size(), 32'd3);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_write_en", {31'd0, write_en}, 32'd0);
        check_eq("async_rst_pending", rd_pending, 32'd0);
        mq.delete();
        exp_q.delete();
        pend_m = 32'd0;
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("rel_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle(); cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
